// File: rtl/strided_buffer_rd_sched.sv
// strided_buffer_rd_sched
// Read-side scheduler for the strided_buffer banks. After the writer flips its
// tile toggle, walks the tile c-innermost, then y, then column group, driving one
// common read address to every bank and presenting each beat to the consumer
// through a valid/ready handshake with dlast and a per-bank column mask.
module strided_buffer_rd_sched #(
   parameter int N_BUF_X    = 5,
   parameter int B_BUF_ADDR = 9,
   parameter int B_SHAPE    = 25
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic [B_SHAPE-1:0]            shape,
   input  logic                          tog,
   output logic [B_BUF_ADDR*N_BUF_X-1:0] rdaddr,
   output logic                          dvalid,
   input  logic                          dready,
   output logic                          dlast,
   output logic [N_BUF_X-1:0]            bank_mask,
   output logic                          busy,
   output logic                          done,
   output logic                          addr_ovf,
   output logic                          tile_ovr
);

   localparam int B_W  = 9;
   localparam int B_H  = 9;
   localparam int B_NC = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t state, state_nxt;

   // shape fields as seen by the scheduler
   logic [B_W-1:0]  shp_w;
   logic [B_H-1:0]  shp_h;
   logic [B_NC-1:0] shp_nc;

   assign shp_w  = shape[8:0];
   assign shp_h  = shape[17:9];
   assign shp_nc = shape[24:18];

   // latched tile geometry and walk counters
   logic [B_H-1:0]        h_r, y;
   logic [B_NC-1:0]       nc_r, c;
   logic [B_W-1:0]        g_max, g;
   logic [N_BUF_X-1:0]    last_mask_r;
   logic [B_BUF_ADDR-1:0] a, rdaddr_r;
   logic                  a_wrap;
   logic                  tog_seen, tog_q;

   // tile geometry derived from the incoming shape
   logic [B_W-1:0]     grp_calc;
   logic [N_BUF_X-1:0] last_mask_calc;
   int                 tail_cols;

   logic pending, zero_shape, stall, issue;
   logic c_last, y_last, g_last, beat_last, accept_last;
   logic start, zero_tile, tile_end;

   assign pending     = tog ^ tog_seen;
   assign zero_shape  = (shp_w == '0) | (shp_h == '0) | (shp_nc == '0);
   assign stall       = dvalid & ~dready;
   assign issue       = (state == S_RUN) & ~stall;
   assign c_last      = (c == nc_r - B_NC'(1));
   assign y_last      = (y == h_r - B_H'(1));
   assign g_last      = (g == g_max);
   assign beat_last   = c_last & y_last & g_last;
   assign accept_last = dvalid & dready & dlast;

   assign busy   = (state != S_IDLE);
   assign rdaddr = {N_BUF_X{rdaddr_r}};

   // group count = ceil(w/N_BUF_X); the last group keeps only its real columns
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      last_mask_calc = '0;
      grp_calc       = B_W'((int'(shp_w) + N_BUF_X - 1) / N_BUF_X);
      tail_cols      = int'(shp_w) - (int'(grp_calc) - 1) * N_BUF_X;
      for (int i = 0; i < N_BUF_X; i++) begin
         last_mask_calc[i] = (i < tail_cols);
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state <= S_IDLE;
      end else if (clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: start a tile on a pending toggle, drain until the last beat is taken
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      zero_tile = 1'b0;
      tile_end  = 1'b0;
      case (state)
         S_IDLE: begin
            if (pending) begin
               if (zero_shape) begin
                  zero_tile = 1'b1;
               end else begin
                  start     = 1'b1;
                  state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (issue & beat_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (accept_last) begin
               tile_end  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // tile walk: address/counter advance and beat registers aligned with bank data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_r         <= '0;
         nc_r        <= '0;
         g_max       <= '0;
         last_mask_r <= '0;
         c           <= '0;
         y           <= '0;
         g           <= '0;
         a           <= '0;
         a_wrap      <= 1'b0;
         rdaddr_r    <= '0;
         dvalid      <= 1'b0;
         dlast       <= 1'b0;
         bank_mask   <= '0;
         addr_ovf    <= 1'b0;
      end else if (clr) begin
         h_r         <= '0;
         nc_r        <= '0;
         g_max       <= '0;
         last_mask_r <= '0;
         c           <= '0;
         y           <= '0;
         g           <= '0;
         a           <= '0;
         a_wrap      <= 1'b0;
         rdaddr_r    <= '0;
         dvalid      <= 1'b0;
         dlast       <= 1'b0;
         bank_mask   <= '0;
         addr_ovf    <= 1'b0;
      end else begin
         if (start) begin
            h_r         <= shp_h;
            nc_r        <= shp_nc;
            g_max       <= grp_calc - B_W'(1);
            last_mask_r <= last_mask_calc;
            c           <= '0;
            y           <= '0;
            g           <= '0;
            a           <= '0;
            a_wrap      <= 1'b0;
         end
         // a held beat keeps rdaddr, so the banks keep driving the same data
         dvalid <= issue | stall;
         if (issue) begin
            rdaddr_r  <= a;
            dlast     <= beat_last;
            bank_mask <= g_last ? last_mask_r : '1;
            a         <= a + B_BUF_ADDR'(1);
            if (&a) a_wrap <= 1'b1;
            // beats issued after the address wrapped read aliased data
            if (a_wrap) addr_ovf <= 1'b1;
            if (c_last) begin
               c <= '0;
               if (y_last) begin
                  y <= '0;
                  g <= g + B_W'(1);
               end else begin
                  y <= y + B_H'(1);
               end
            end else begin
               c <= c + B_NC'(1);
            end
         end else if (!stall) begin
            dlast     <= 1'b0;
            bank_mask <= '0;
         end
      end
   end

   // tile bookkeeping: done pulse, toggle acknowledge, overrun detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done     <= 1'b0;
         tog_seen <= 1'b0;
         tog_q    <= 1'b0;
         tile_ovr <= 1'b0;
      end else if (clr) begin
         done     <= 1'b0;
         tog_seen <= 1'b0;
         tog_q    <= 1'b0;
         tile_ovr <= 1'b0;
      end else begin
         tog_q <= tog;
         done  <= zero_tile | tile_end;
         if (zero_tile | tile_end) tog_seen <= ~tog_seen;
         // while busy, tog_q == tog_seen means one extra edge is already queued
         if (busy && (tog ^ tog_q) && (tog_q == tog_seen)) tile_ovr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_strided_buffer_rd_sched.sv
// tb_strided_buffer_rd_sched
// Self-checking bench: a beat-list model of each tile is compared against every
// presented beat; directed cases pin latency, stalls, overrun, overflow and aborts,
// then random shapes run with random consumer back-pressure.
module tb_strided_buffer_rd_sched;

   localparam int N  = 5;
   localparam int BA = 9;

   logic          clk = 1'b0;
   logic          rst, clr, tog, dready;
   logic [24:0]   shape;
   logic [N*BA-1:0] rdaddr;
   logic          dvalid, dlast, busy, done, addr_ovf, tile_ovr;
   logic [N-1:0]  bank_mask;

   always #5 clk = ~clk;

   strided_buffer_rd_sched #(
      .N_BUF_X   (N),
      .B_BUF_ADDR(BA),
      .B_SHAPE   (25)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shape    (shape),
      .tog      (tog),
      .rdaddr   (rdaddr),
      .dvalid   (dvalid),
      .dready   (dready),
      .dlast    (dlast),
      .bank_mask(bank_mask),
      .busy     (busy),
      .done     (done),
      .addr_ovf (addr_ovf),
      .tile_ovr (tile_ovr)
   );

   typedef struct {
      int           addr;
      logic [N-1:0] mask;
      bit           last;
      bit           ovf;
   } beat_t;

   beat_t exp_q[$];
   beat_t cur;
   int    n_checks = 0;
   int    n_err    = 0;
   int    n_acc    = 0;
   int    n_done   = 0;
   bit    chk_en   = 1'b0;
   bit    chk_done = 1'b1;
   bit    rand_rdy = 1'b0;
   bit    last_acc_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected beat list of one tile: c innermost, then y, then column group
   function automatic void push_tile(input int w, input int h, input int nc, input int max_beats);
      int    groups;
      int    total;
      int    idx;
      beat_t b;
      groups = (w + N - 1) / N;
      total  = groups * h * nc;
      idx    = 0;
      for (int gi = 0; gi < groups; gi++) begin
         for (int yi = 0; yi < h; yi++) begin
            for (int ci = 0; ci < nc; ci++) begin
               if (idx >= max_beats) return;
               b.addr = idx % (1 << BA);
               for (int i = 0; i < N; i++) b.mask[i] = (gi * N + i < w);
               b.last = (idx == total - 1);
               b.ovf  = (idx >= (1 << BA));
               exp_q.push_back(b);
               idx++;
            end
         end
      end
   endfunction

   // compare process: every presented beat against the model, done against last acceptance
   always @(negedge clk) begin
      bit acc_last;
      acc_last = 1'b0;
      if (done) n_done++;
      if (chk_en) begin
         check("spurious_dvalid", 64'(dvalid && exp_q.size() == 0), 64'd0);
         if (dvalid && exp_q.size() != 0) begin
            check("rdaddr", 64'(rdaddr), 64'({N{exp_q[0].addr[BA-1:0]}}));
            check("bank_mask", 64'(bank_mask), 64'(exp_q[0].mask));
            check("dlast", 64'(dlast), 64'(exp_q[0].last));
            check("addr_ovf", 64'(addr_ovf), 64'(exp_q[0].ovf));
            if (dready) begin
               cur      = exp_q.pop_front();
               acc_last = cur.last;
               n_acc++;
            end
         end
         if (chk_done) check("done", 64'(done), 64'(last_acc_prev));
      end
      last_acc_prev = acc_last;
   end

   // random consumer back-pressure when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) dready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_shape(input int w, input int h, input int nc);
      shape = {7'(nc), 9'(h), 9'(w)};
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy || done) && n < budget) begin
         tick();
         n++;
      end
      check("drain_in_budget", 64'(n < budget), 64'd1);
      tick(2);
   endtask

   task automatic wait_addr(input int addr, input int budget);
      int n;
      n = 0;
      while (!(dvalid && rdaddr[BA-1:0] == BA'(addr)) && n < budget) begin
         tick();
         n++;
      end
      check("addr_seen_in_budget", 64'(n < budget), 64'd1);
   endtask

   task automatic do_clear();
      clr = 1'b1;
      tog = 1'b0;
      tick();
      clr = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int d0, a0, n;
      rst = 1'b1; clr = 1'b0; tog = 1'b0; dready = 1'b0; shape = '0;
      #12;
      check("rst_rdaddr", 64'(rdaddr), 64'd0);
      check("rst_dvalid", 64'(dvalid), 64'd0);
      check("rst_dlast", 64'(dlast), 64'd0);
      check("rst_mask", 64'(bank_mask), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_flags", 64'({addr_ovf, tile_ovr}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      tick(2);

      // 1: 10x2x2, full throughput, latency pinned
      dready = 1'b1;
      set_shape(10, 2, 2);
      push_tile(10, 2, 2, 1 << 30);
      d0 = n_done; a0 = n_acc;
      tog = ~tog;
      tick();
      check("t1_busy_on_entry", 64'(busy), 64'd1);
      check("t1_no_dvalid_on_entry", 64'(dvalid), 64'd0);
      tick();
      check("t1_first_dvalid", 64'(dvalid), 64'd1);
      check("t1_first_addr", 64'(rdaddr[BA-1:0]), 64'd0);
      check("t1_first_mask", 64'(bank_mask), 64'h1F);
      wait_idle(100);
      check("t1_beats", 64'(n_acc - a0), 64'd8);
      check("t1_done_pulses", 64'(n_done - d0), 64'd1);

      // 2: 7x1x1, partial last group
      set_shape(7, 1, 1);
      push_tile(7, 1, 1, 1 << 30);
      tog = ~tog;
      tick(2);
      check("t2_beat1_mask", 64'(bank_mask), 64'h1F);
      check("t2_beat1_last", 64'(dlast), 64'd0);
      tick();
      check("t2_beat2_addr", 64'(rdaddr[BA-1:0]), 64'd1);
      check("t2_beat2_mask", 64'(bank_mask), 64'b00011);
      check("t2_beat2_last", 64'(dlast), 64'd1);
      wait_idle(50);

      // 3: stall three cycles on beat 4
      set_shape(10, 2, 2);
      push_tile(10, 2, 2, 1 << 30);
      a0 = n_acc;
      tog = ~tog;
      wait_addr(2, 20);
      tick();
      dready = 1'b0;
      tick(3);
      check("t3_held_addr", 64'(rdaddr[BA-1:0]), 64'd3);
      check("t3_held_valid", 64'(dvalid), 64'd1);
      dready = 1'b1;
      wait_idle(100);
      check("t3_beats", 64'(n_acc - a0), 64'd8);

      // 4a: two edges during RUN -> overrun, extra tile dropped
      set_shape(10, 2, 2);
      push_tile(10, 2, 2, 1 << 30);
      d0 = n_done;
      tog = ~tog;
      tick(3);
      tog = ~tog;
      tick(2);
      tog = ~tog;
      wait_idle(100);
      tick(10);
      check("t4_tile_ovr", 64'(tile_ovr), 64'd1);
      check("t4_one_done", 64'(n_done - d0), 64'd1);
      do_clear();
      check("t4_ovr_cleared", 64'(tile_ovr), 64'd0);

      // 4b: one edge during RUN -> second tile after done, shape change ignored mid-run
      set_shape(10, 2, 2);
      push_tile(10, 2, 2, 1 << 30);
      push_tile(7, 1, 1, 1 << 30);
      d0 = n_done; a0 = n_acc;
      tog = ~tog;
      tick(3);
      set_shape(7, 1, 1);
      tog = ~tog;
      wait_idle(200);
      check("t4b_no_ovr", 64'(tile_ovr), 64'd0);
      check("t4b_beats", 64'(n_acc - a0), 64'd10);
      check("t4b_done_pulses", 64'(n_done - d0), 64'd2);

      // 5a: empty tiles pulse done once and present nothing
      chk_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) set_shape(0, 3, 3);
         else if (k == 1) set_shape(4, 0, 2);
         else set_shape(4, 2, 0);
         d0 = n_done;
         tog = ~tog;
         tick(4);
         check("t5_empty_done", 64'(n_done - d0), 64'd1);
         check("t5_empty_idle", 64'(busy), 64'd0);
      end
      chk_done = 1'b1;

      // 5b: address overflow at beat 513 of a 511x511x1 tile
      set_shape(511, 511, 1);
      push_tile(511, 511, 1, 600);
      a0 = n_acc;
      tog = ~tog;
      n = 0;
      while (n_acc - a0 < 520 && n < 700) begin
         tick();
         n++;
      end
      check("t5_ovf_in_budget", 64'(n < 700), 64'd1);
      check("t5_addr_ovf", 64'(addr_ovf), 64'd1);
      do_clear();
      check("t5_ovf_cleared", 64'(addr_ovf), 64'd0);

      // 6: clr at beat 3 aborts without done
      set_shape(10, 2, 2);
      push_tile(10, 2, 2, 1 << 30);
      d0 = n_done;
      tog = ~tog;
      wait_addr(2, 20);
      do_clear();
      check("t6_clr_dvalid", 64'(dvalid), 64'd0);
      check("t6_clr_busy", 64'(busy), 64'd0);
      check("t6_clr_outs", 64'({rdaddr, bank_mask, dlast, done}), 64'd0);
      tick(5);
      check("t6_clr_no_done", 64'(n_done - d0), 64'd0);

      // 6b: asynchronous rst mid-tile
      set_shape(10, 2, 2);
      push_tile(10, 2, 2, 1 << 30);
      tog = ~tog;
      tick(4);
      chk_en = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("t6_rst_dvalid", 64'(dvalid), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_outs", 64'({rdaddr, bank_mask, dlast, done, addr_ovf, tile_ovr}), 64'd0);
      tog = 1'b0;
      tick(2);
      rst = 1'b0;
      exp_q.delete();
      chk_en = 1'b1;
      tick(3);
      check("t6_after_rst_idle", 64'(busy), 64'd0);

      // random shapes with random back-pressure
      rand_rdy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         int w, h, nc;
         w  = $urandom_range(1, 23);
         h  = $urandom_range(1, 4);
         nc = $urandom_range(1, 4);
         set_shape(w, h, nc);
         push_tile(w, h, nc, 1 << 30);
         d0 = n_done;
         tog = ~tog;
         wait_idle(600);
         check("rand_done", 64'(n_done - d0), 64'd1);
      end
      rand_rdy = 1'b0;
      check("final_no_flags", 64'({addr_ovf, tile_ovr}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
